// File: rtl/vram_dma.sv
// vram_dma -- byte-copy engine from system memory into the GPU VRAM write port.
//
// Copies up to MAX_LEN bytes from system memory into VRAM. The VRAM port is
// shared with direct CPU writes, and a CPU write always takes the port. A
// transfer can optionally be held to vertical blanking so that sprite tables
// are never updated mid-frame.
//
// Ports
//   cpu_clk, rst           clock (rising edge), synchronous active-high reset
//   cfg_start              one-cycle start strobe, accepted only when idle
//   cfg_src/dst/len        source address, VRAM destination, byte count
//   cfg_wait_vblank        copy only while vblank is high
//   vblank                 blanking level input
//   mem_rd_en/mem_addr     system memory read request, held until mem_gnt
//   mem_gnt/mem_rd_data    grant this cycle; data arrives the following cycle
//   cpu_vram_we/addr/data  direct CPU VRAM write, has priority over the DMA
//   vram_address/data/we   shared VRAM write port
//   select_pmf/select_obm  pattern (0x000-0x1FF) / object (0x800-0x8FF) select
//   busy, done, err        in progress, completion pulse, sticky start-while-busy
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for cfg_start
// WAIT_VB  | start accepted with vblank wait, vblank still low
// XFER     | issuing reads and draining the skid FIFO into VRAM
// FINISH   | single cycle, done pulse

module vram_dma #(
  parameter int ADDR_W  = 12,
  parameter int SRC_W   = 16,
  parameter int MAX_LEN = 512
) (
  input  logic              cpu_clk,
  input  logic              rst,
  input  logic              cfg_start,
  input  logic [SRC_W-1:0]  cfg_src,
  input  logic [ADDR_W-1:0] cfg_dst,
  input  logic [9:0]        cfg_len,
  input  logic              cfg_wait_vblank,
  input  logic              vblank,
  output logic              mem_rd_en,
  output logic [SRC_W-1:0]  mem_addr,
  input  logic              mem_gnt,
  input  logic [7:0]        mem_rd_data,
  input  logic              cpu_vram_we,
  input  logic [ADDR_W-1:0] cpu_vram_addr,
  input  logic [7:0]        cpu_vram_data,
  output logic [ADDR_W-1:0] vram_address,
  output logic [7:0]        vram_data,
  output logic              vram_we,
  output logic              select_pmf,
  output logic              select_obm,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT_VB = 2'd1,
    S_XFER    = 2'd2,
    S_FINISH  = 2'd3
  } state_t;

  localparam logic [9:0] LEN_CAP = 10'(MAX_LEN);

  state_t            state, state_nxt;
  logic [SRC_W-1:0]  src_q;
  logic [ADDR_W-1:0] dst_q;
  logic [9:0]        len_q;
  logic              wait_q;
  logic [9:0]        issued;
  logic [9:0]        written;
  logic              inflight;

  logic [7:0]        fifo_mem [2];
  logic              rd_ptr, wr_ptr;
  logic [1:0]        fifo_count;

  logic [9:0]        len_clamped;
  logic              start_ok;
  logic              gate_open;
  logic              dma_pop;
  logic              issue;
  logic [2:0]        slots_used;

  assign len_clamped = (cfg_len > LEN_CAP) ? LEN_CAP : cfg_len;
  assign start_ok    = cfg_start && (state == S_IDLE);
  assign gate_open   = !wait_q || vblank;

  // DMA drains only when the CPU leaves the port alone; suppressed in reset.
  assign dma_pop = !rst && (state == S_XFER) && (fifo_count != 2'd0) && !cpu_vram_we;

  // A slot is reserved for every read still in flight, so the FIFO cannot
  // overflow however long the CPU holds the port.
  assign slots_used = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, dma_pop};

  assign mem_rd_en = !rst && (state == S_XFER) && (issued < len_q) && gate_open
                     && (slots_used < 3'd2);
  assign mem_addr  = src_q + SRC_W'(issued);
  assign issue     = mem_rd_en && mem_gnt;

  always_comb begin
    vram_address = dst_q + ADDR_W'(written);
    vram_data    = fifo_mem[rd_ptr];
    vram_we      = dma_pop;
    if (cpu_vram_we) begin
      vram_address = cpu_vram_addr;
      vram_data    = cpu_vram_data;
      vram_we      = 1'b1;
    end
  end

  assign select_pmf = (vram_address < ADDR_W'('h200));
  assign select_obm = (vram_address >= ADDR_W'('h800)) && (vram_address <= ADDR_W'('h8FF));

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (cfg_start) begin
          if (len_clamped == 10'd0)
            state_nxt = S_FINISH;
          else if (cfg_wait_vblank && !vblank)
            state_nxt = S_WAIT_VB;
          else
            state_nxt = S_XFER;
        end
      end
      S_WAIT_VB: begin
        busy = 1'b1;
        if (vblank)
          state_nxt = S_XFER;
      end
      S_XFER: begin
        busy = 1'b1;
        // Leave on the cycle of the last pop so done lands one cycle later.
        if ((written + 10'(dma_pop)) == len_q)
          state_nxt = S_FINISH;
      end
      S_FINISH: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge cpu_clk) begin
    if (rst) begin
      state       <= S_IDLE;
      src_q       <= '0;
      dst_q       <= '0;
      len_q       <= '0;
      wait_q      <= 1'b0;
      issued      <= '0;
      written     <= '0;
      inflight    <= 1'b0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      fifo_count  <= 2'd0;
      err         <= 1'b0;
      fifo_mem[0] <= 8'h00;
      fifo_mem[1] <= 8'h00;
    end else begin
      state <= state_nxt;

      if (start_ok) begin
        src_q   <= cfg_src;
        dst_q   <= cfg_dst;
        len_q   <= len_clamped;
        wait_q  <= cfg_wait_vblank;
        issued  <= '0;
        written <= '0;
        err     <= 1'b0;
      end else begin
        if (cfg_start)
          err <= 1'b1;
        if (issue)
          issued <= issued + 10'd1;
        if (dma_pop)
          written <= written + 10'd1;
      end

      // Data for a read granted last cycle is on mem_rd_data now.
      inflight <= issue;
      if (inflight) begin
        fifo_mem[wr_ptr] <= mem_rd_data;
        wr_ptr           <= ~wr_ptr;
      end
      if (dma_pop)
        rd_ptr <= ~rd_ptr;

      case ({inflight, dma_pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule

// File: tb/tb_vram_dma.sv
// tb_vram_dma -- directed self-checking bench for vram_dma.
//
// A system memory model answers granted reads one cycle later with a byte
// derived from the address, and a VRAM model records every write on negedge.
// A vector table covers plain copies and length/address boundaries; hand
// sequences cover CPU contention, vblank gating, grant stalls, err and reset.

module tb_vram_dma;

  logic        cpu_clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_start = 1'b0;
  logic [15:0] cfg_src = '0;
  logic [11:0] cfg_dst = '0;
  logic [9:0]  cfg_len = '0;
  logic        cfg_wait_vblank = 1'b0;
  logic        vblank = 1'b1;
  logic        mem_gnt = 1'b1;
  logic [7:0]  mem_rd_data = '0;
  logic        cpu_vram_we = 1'b0;
  logic [11:0] cpu_vram_addr = '0;
  logic [7:0]  cpu_vram_data = '0;

  logic        mem_rd_en;
  logic [15:0] mem_addr;
  logic [11:0] vram_address;
  logic [7:0]  vram_data;
  logic        vram_we, select_pmf, select_obm, busy, done, err;

  vram_dma #(.ADDR_W(12), .SRC_W(16), .MAX_LEN(512)) dut (
    .cpu_clk(cpu_clk), .rst(rst),
    .cfg_start(cfg_start), .cfg_src(cfg_src), .cfg_dst(cfg_dst), .cfg_len(cfg_len),
    .cfg_wait_vblank(cfg_wait_vblank), .vblank(vblank),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_gnt(mem_gnt), .mem_rd_data(mem_rd_data),
    .cpu_vram_we(cpu_vram_we), .cpu_vram_addr(cpu_vram_addr), .cpu_vram_data(cpu_vram_data),
    .vram_address(vram_address), .vram_data(vram_data), .vram_we(vram_we),
    .select_pmf(select_pmf), .select_obm(select_obm),
    .busy(busy), .done(done), .err(err)
  );

  always #5 cpu_clk = ~cpu_clk;

  int total = 0;
  int bad = 0;

  function automatic void chk(input string nm, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endfunction

  function automatic logic [7:0] src_byte(input logic [15:0] a);
    return a[7:0] ^ {a[10:8], a[15:11]} ^ 8'h3C;
  endfunction

  int cyc = 0;
  int start_cyc = 0;
  always @(posedge cpu_clk) cyc <= cyc + 1;

  // System memory: a read granted in cycle N returns its byte during N+1.
  logic        mdl_acc = 1'b0;
  logic [15:0] mdl_addr = '0;
  always @(negedge cpu_clk) begin
    mdl_acc  <= mem_rd_en && mem_gnt;
    mdl_addr <= mem_addr;
  end
  always @(posedge cpu_clk)
    if (mdl_acc) mem_rd_data <= src_byte(mdl_addr);

  // Grant pattern 1,0,0,1 repeating while gnt_stall is set.
  logic gnt_stall = 1'b0;
  always @(posedge cpu_clk) begin
    #1;
    mem_gnt = gnt_stall ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
  end

  // Monitor / VRAM model
  logic [7:0]  vram_mem [4096];
  logic [11:0] w_addr [$];
  logic [7:0]  w_data [$];
  logic [15:0] acc_q [$];
  int done_cnt, done_rel, first_rd, first_wr, last_wr, busy_cnt, non_obm, holds, rd_closed;
  logic first_pmf, first_obm;
  logic vb_chk = 1'b0;
  logic hold_prev = 1'b0;
  logic [15:0] hold_addr = '0;
  int rel;

  always @(negedge cpu_clk) begin
    rel = cyc - start_cyc;
    if (done) begin
      done_cnt++;
      done_rel = rel;
    end
    if (busy) busy_cnt++;
    if (mem_rd_en && first_rd < 0) first_rd = rel;
    if (mem_rd_en && mem_gnt) acc_q.push_back(mem_addr);
    if (vb_chk && !vblank && mem_rd_en) rd_closed++;
    if (vram_we) vram_mem[vram_address] = vram_data;
    if (vram_we && !cpu_vram_we) begin
      if (w_addr.size() == 0) begin
        first_wr  = rel;
        first_pmf = select_pmf;
        first_obm = select_obm;
      end
      last_wr = rel;
      if (!select_obm) non_obm++;
      w_addr.push_back(vram_address);
      w_data.push_back(vram_data);
    end
    if (!rst && hold_prev) begin
      holds++;
      chk("gnt_hold_en", int'(mem_rd_en), 1);
      chk("gnt_hold_addr", int'(mem_addr), int'(hold_addr));
    end
    hold_prev = !rst && mem_rd_en && !mem_gnt;
    hold_addr = mem_addr;
  end

  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic clear_logs();
    w_addr.delete();
    w_data.delete();
    acc_q.delete();
    done_cnt = 0; done_rel = -1; first_rd = -1; first_wr = -1; last_wr = -1;
    busy_cnt = 0; non_obm = 0; holds = 0; rd_closed = 0;
    first_pmf = 1'b0; first_obm = 1'b0;
  endtask

  task automatic start(input logic [15:0] s, input logic [11:0] d, input logic [9:0] l,
                       input logic w);
    clear_logs();
    cfg_src = s; cfg_dst = d; cfg_len = l; cfg_wait_vblank = w;
    cfg_start = 1'b1;
    start_cyc = cyc;
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      tick();
      n++;
    end
    chk(nm, done_cnt, 1);
    tick();
  endtask

  task automatic check_data(input string nm, input logic [15:0] s, input logic [11:0] d);
    int e = 0;
    for (int i = 0; i < w_addr.size(); i++)
      if (w_addr[i] != 12'(d + i) || w_data[i] != src_byte(16'(s + i))) e++;
    chk(nm, e, 0);
  endtask

  typedef struct {
    logic [15:0] src;
    logic [11:0] dst;
    logic [9:0]  len;
    int exp_wr, exp_first_rd, exp_first_wr, exp_done, exp_busy;
    logic exp_pmf, exp_obm;
  } copy_vec_t;

  typedef struct {
    logic [11:0] addr;
    logic pmf, obm;
  } dec_vec_t;

  copy_vec_t cv [7];
  dec_vec_t  dv [8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cv[0] = '{16'h0300, 12'h800, 10'd4,   4,   1,  3,  7,   6,   1'b0, 1'b1};
    cv[1] = '{16'h1234, 12'h000, 10'd16,  16,  1,  3,  19,  18,  1'b1, 1'b0};
    cv[2] = '{16'hFFFE, 12'h100, 10'd5,   5,   1,  3,  8,   7,   1'b1, 1'b0};
    cv[3] = '{16'h0000, 12'hFFE, 10'd4,   4,   1,  3,  7,   6,   1'b0, 1'b0};
    cv[4] = '{16'h0010, 12'h800, 10'd0,   0,   -1, -1, 1,   0,   1'b0, 1'b0};
    cv[5] = '{16'h4000, 12'h000, 10'd700, 512, 1,  3,  515, 514, 1'b1, 1'b0};
    cv[6] = '{16'h8000, 12'h800, 10'd512, 512, 1,  3,  515, 514, 1'b0, 1'b1};

    dv[0] = '{12'h000, 1'b1, 1'b0};
    dv[1] = '{12'h1FF, 1'b1, 1'b0};
    dv[2] = '{12'h200, 1'b0, 1'b0};
    dv[3] = '{12'h7FF, 1'b0, 1'b0};
    dv[4] = '{12'h800, 1'b0, 1'b1};
    dv[5] = '{12'h8FF, 1'b0, 1'b1};
    dv[6] = '{12'h900, 1'b0, 1'b0};
    dv[7] = '{12'hFFF, 1'b0, 1'b0};

    for (int i = 0; i < 4096; i++) vram_mem[i] = 8'h00;
    clear_logs();

    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_rd_en", int'(mem_rd_en), 0);
    chk("rst_mem_addr", int'(mem_addr), 0);
    chk("rst_vram_we", int'(vram_we), 0);

    // Address decode through CPU passthrough
    for (int i = 0; i < 8; i++) begin
      cpu_vram_we = 1'b1; cpu_vram_addr = dv[i].addr; cpu_vram_data = 8'(i);
      #1;
      chk($sformatf("dec_addr[%0d]", i), int'(vram_address), int'(dv[i].addr));
      chk($sformatf("dec_pmf[%0d]", i), int'(select_pmf), int'(dv[i].pmf));
      chk($sformatf("dec_obm[%0d]", i), int'(select_obm), int'(dv[i].obm));
      tick();
    end
    cpu_vram_we = 1'b0;
    tick();

    // Plain copies and boundaries
    for (int v = 0; v < 7; v++) begin
      start(cv[v].src, cv[v].dst, cv[v].len, 1'b0);
      wait_done($sformatf("v%0d_done_seen", v), 600);
      chk($sformatf("v%0d_done_cyc", v), done_rel, cv[v].exp_done);
      chk($sformatf("v%0d_writes", v), w_addr.size(), cv[v].exp_wr);
      chk($sformatf("v%0d_first_rd", v), first_rd, cv[v].exp_first_rd);
      chk($sformatf("v%0d_first_wr", v), first_wr, cv[v].exp_first_wr);
      chk($sformatf("v%0d_last_wr", v), last_wr, (cv[v].exp_wr > 0) ? cv[v].exp_done - 1 : -1);
      chk($sformatf("v%0d_busy_cycles", v), busy_cnt, cv[v].exp_busy);
      chk($sformatf("v%0d_first_pmf", v), int'(first_pmf), int'(cv[v].exp_pmf));
      chk($sformatf("v%0d_first_obm", v), int'(first_obm), int'(cv[v].exp_obm));
      check_data($sformatf("v%0d_data", v), cv[v].src, cv[v].dst);
    end

    // CPU contention in cycles 4 and 5
    start(16'h0400, 12'h000, 10'd8, 1'b0);
    repeat (3) tick();
    cpu_vram_we = 1'b1; cpu_vram_addr = 12'h850; cpu_vram_data = 8'hA5;
    #1;
    chk("cpu_pass_we", int'(vram_we), 1);
    chk("cpu_pass_addr", int'(vram_address), 'h850);
    chk("cpu_pass_data", int'(vram_data), 'hA5);
    tick();
    cpu_vram_addr = 12'h851; cpu_vram_data = 8'hA6;
    tick();
    cpu_vram_we = 1'b0;
    wait_done("cpu_done_seen", 50);
    chk("cpu_done_cyc", done_rel, 13);
    chk("cpu_writes", w_addr.size(), 8);
    check_data("cpu_dma_data", 16'h0400, 12'h000);
    begin
      int e = 0;
      for (int i = 0; i < 8; i++)
        if (vram_mem[i] != src_byte(16'(16'h0400 + i))) e++;
      chk("cpu_pmf_bytes", e, 0);
    end
    chk("cpu_byte0", int'(vram_mem[12'h850]), 'hA5);
    chk("cpu_byte1", int'(vram_mem[12'h851]), 'hA6);

    // Vblank gating
    vblank = 1'b0;
    start(16'h2000, 12'h800, 10'd256, 1'b1);
    repeat (10) tick();
    chk("vb_no_read", first_rd, -1);
    chk("vb_wait_busy", int'(busy), 1);
    vblank = 1'b1;
    begin
      int g = 0;
      int n0;
      while (w_addr.size() < 100 && g < 400) begin
        tick();
        g++;
      end
      chk("vb_reach_100", int'(w_addr.size() >= 100), 1);
      vblank = 1'b0;
      vb_chk = 1'b1;
      n0 = w_addr.size();
      repeat (30) tick();
      chk("vb_stop_within_2", int'((w_addr.size() - n0) <= 2), 1);
      chk("vb_no_issue_closed", rd_closed, 0);
      chk("vb_still_busy", int'(busy), 1);
      vb_chk = 1'b0;
    end
    vblank = 1'b1;
    wait_done("vb_done_seen", 600);
    chk("vb_writes", w_addr.size(), 256);
    check_data("vb_data", 16'h2000, 12'h800);
    chk("vb_all_obm", non_obm, 0);
    begin
      int e = 0;
      for (int i = 0; i < 256; i++)
        if (vram_mem[12'h800 + i] != src_byte(16'(16'h2000 + i))) e++;
      chk("vb_obm_bytes", e, 0);
    end

    // Grant stalls
    gnt_stall = 1'b1;
    start(16'h0050, 12'h810, 10'd6, 1'b0);
    wait_done("gnt_done_seen", 100);
    gnt_stall = 1'b0;
    chk("gnt_writes", w_addr.size(), 6);
    check_data("gnt_data", 16'h0050, 12'h810);
    chk("gnt_reads", acc_q.size(), 6);
    begin
      int e = 0;
      for (int i = 0; i < acc_q.size(); i++)
        if (acc_q[i] != 16'(16'h0050 + i)) e++;
      chk("gnt_read_seq", e, 0);
    end
    chk("gnt_hold_seen", int'(holds > 0), 1);

    // Start while busy
    start(16'h0600, 12'h820, 10'd8, 1'b0);
    repeat (2) tick();
    cfg_src = 16'h0000; cfg_dst = 12'h000; cfg_len = 10'd2;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    chk("err_set", int'(err), 1);
    wait_done("err_done_seen", 50);
    chk("err_done_cyc", done_rel, 11);
    chk("err_writes", w_addr.size(), 8);
    check_data("err_data", 16'h0600, 12'h820);
    chk("err_sticky", int'(err), 1);
    start(16'h0300, 12'h800, 10'd4, 1'b0);
    chk("err_cleared", int'(err), 0);
    wait_done("err2_done_seen", 50);
    chk("err2_done_cyc", done_rel, 7);

    // Reset mid-transfer
    start(16'h0700, 12'h000, 10'd16, 1'b0);
    repeat (4) tick();
    rst = 1'b1;
    cpu_vram_we = 1'b1; cpu_vram_addr = 12'h123; cpu_vram_data = 8'h77;
    #1;
    chk("rst_cpu_we", int'(vram_we), 1);
    chk("rst_cpu_addr", int'(vram_address), 'h123);
    chk("rst_no_rd", int'(mem_rd_en), 0);
    tick();
    rst = 1'b0;
    cpu_vram_we = 1'b0;
    #1;
    chk("rst_idle_busy", int'(busy), 0);
    repeat (10) tick();
    chk("rst_no_done", done_cnt, 0);
    chk("rst_writes", w_addr.size(), 2);
    check_data("rst_data", 16'h0700, 12'h000);
    chk("rst_cpu_byte", int'(vram_mem[12'h123]), 'h77);
    start(16'h0300, 12'h800, 10'd4, 1'b0);
    wait_done("post_rst_done_seen", 50);
    chk("post_rst_done_cyc", done_rel, 7);
    chk("post_rst_first_wr", first_wr, 3);
    chk("post_rst_writes", w_addr.size(), 4);
    check_data("post_rst_data", 16'h0300, 12'h800);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vram_dma.md
# vram_dma

Byte-copy engine feeding the GPU VRAM write port (pattern memory PMF at 0x000–0x1FF, object memory OBM at 0x800–0x8FF) from system memory. It arbitrates that port between direct CPU writes, which always win, and its own transfers. It can optionally restrict transfers to vertical blanking so sprite tables are never torn mid-frame. It sits between the CPU bus and the foreground/background VRAM blocks, in the cpu_clk domain.

## Interface
- `ADDR_W`, 12, VRAM address width
- `SRC_W`, 16, system memory address width
- `MAX_LEN`, 512, largest transfer in bytes; larger requests are clamped
- `cpu_clk` in 1: the only clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `cfg_start` in 1: one-cycle start strobe
- `cfg_src` in SRC_W: source byte address
- `cfg_dst` in ADDR_W: VRAM destination address
- `cfg_len` in 10: byte count
- `cfg_wait_vblank` in 1: transfer only while `vblank` is high
- `vblank` in 1: level input, high during blanking
- `mem_rd_en` out 1: read request
- `mem_addr` out SRC_W: read address
- `mem_gnt` in 1: read accepted this cycle
- `mem_rd_data` in 8: data, valid the cycle after an accepted read
- `cpu_vram_we` in 1: direct CPU VRAM write
- `cpu_vram_addr` in ADDR_W: direct CPU VRAM address
- `cpu_vram_data` in 8: direct CPU VRAM data
- `vram_address` out ADDR_W: VRAM port address
- `vram_data` out 8: VRAM port data
- `vram_we` out 1: VRAM port write enable
- `select_pmf` out 1: PMF select
- `select_obm` out 1: OBM select
- `busy` out 1: transfer in progress
- `done` out 1: one-cycle completion pulse
- `err` out 1: sticky start-while-busy flag

## Operation
- **State machine:** IDLE → (WAIT_VB) → XFER → FINISH → IDLE.
- **IDLE, start accepted:** `cfg_start` is accepted only in IDLE. On acceptance the block:
  - latches src, dst and wait flag;
  - sets len = min(`cfg_len`, MAX_LEN);
  - clears `err`;
  - goes to XFER, or to WAIT_VB if `cfg_wait_vblank` is set and `vblank` is low.
- **Zero length:** len = 0 goes straight to FINISH.
- **Start while busy:** a `cfg_start` outside IDLE is ignored and sets `err`.
- **WAIT_VB:** moves to XFER on the cycle after `vblank` is seen high.
- **XFER, read issue:**
  - `mem_rd_en` is asserted when issued < len AND the vblank gate is open AND (fifo_count + inflight − draining) < 2.
  - A read counts as issued only when `mem_gnt` is high that cycle; otherwise `mem_rd_en` and `mem_addr` are held.
  - `mem_addr` = src + issued, wrapping modulo 2^SRC_W.
- **Skid buffer:** a 2-entry FIFO captures `mem_rd_data` at the end of the cycle after the accepted read.
- **Vblank gate:** when wait is set and `vblank` falls, new issues stop. In-flight reads complete and drain into the FIFO. Issuing resumes at the next high `vblank`; the state stays XFER.
- **Port arbitration (combinational):**
  - `cpu_vram_we` = 1: the CPU address, data and write enable pass through, and the FIFO does not drain.
  - Otherwise, a non-empty FIFO drives its head byte to dst + written (modulo 2^ADDR_W) with `vram_we` = 1, and pops.
- **Address decode** on `vram_address`:
  - `select_pmf` = addr < 0x200.
  - `select_obm` = addr in 0x800–0x8FF.
  - Any other address selects neither; a DMA byte to such an address is still counted written and simply dropped by VRAM.
- **Completion:**
  - XFER → FINISH when written = len.
  - FINISH lasts one cycle with `done` = 1, then IDLE.
  - `busy` = 1 in WAIT_VB and XFER, 0 in FINISH.
- **Counters:** issued and written are 10 bits each; inflight is 0 or 1.

## Timing
- **Reset values:** state IDLE, FIFO empty, counters 0, `busy` = `done` = `err` = `mem_rd_en` = 0, `mem_addr` = 0.
- **Reset mid-transfer:** aborts the transfer with no `done` pulse. DMA writes are suppressed in the reset cycle; CPU passthrough stays live.
- **Latency with no contention:**
  - start at cycle 0;
  - `mem_rd_en` from cycle 1;
  - first `vram_we` at cycle 3;
  - one byte per cycle;
  - last write at cycle len+2;
  - `done` at cycle len+3.
- **Write timing:** all DMA-side outputs are registered or combinational from registers on posedge. The VRAM samples on negedge, so address, data and selects are stable mid-cycle.
- **CPU priority:** a CPU write stalls the DMA exactly one cycle. The FIFO never overflows, because issue accounting reserves a slot for every in-flight read.

## Test plan
- **Basic copy:** start, src = 0x0300, dst = 0x800, len = 4, no wait, `mem_gnt` = 1 → `vram_we` at cycles 3–6 to 0x800–0x803 with `select_obm` = 1, `done` at cycle 7, `busy` high during cycles 1–6.
- **CPU contention:** len = 8 to dst 0x000, `cpu_vram_we` high in cycles 4 and 5 → CPU writes pass through in those cycles, DMA bytes arrive in order without loss, `done` at cycle 13, PMF bytes 0–7 match source.
- **Vblank gating:** wait = 1, `vblank` low at start → no `mem_rd_en` until `vblank` rises. With len = 256 and `vblank` dropping after 100 writes, writes stop within 2 cycles and resume at the next vblank; all 256 OBM bytes are correct.
- **Grant stalls:** `mem_gnt` toggled 1,0,0,1… → `mem_addr` held while `mem_gnt` = 0, no duplicated or skipped source bytes.
- **Edge cases:**
  - len = 0 → `done` one cycle after start, no writes;
  - len = 700 → exactly 512 writes;
  - dst = 0xFFE, len = 4 → addresses 0xFFE, 0xFFF, 0x000, 0x001.
- **Error and reset:**
  - `cfg_start` while busy → `err` = 1 and the transfer is unaffected;
  - the next accepted start clears `err`;
  - `rst` mid-transfer → IDLE the next cycle, no `done`, the next start behaves as in the basic copy.
